// File: rtl/mem_pkg.sv
// Shared types and op-decoding helpers for the memory access unit.
package mem_pkg;

  typedef enum logic [3:0] {
    OP_NONE, LD_B, LD_BU, LD_H, LD_HU, LD_W, LD_WU, LD_D, ST_B, ST_H, ST_W, ST_D
  } op_e;

  typedef enum logic [2:0] {IDLE, REQ, WAIT, DONE, DRAIN} state_e;

  // log2 of the access size in bytes
  function automatic logic [1:0] op_size(op_e op);
    case (op)
      LD_H, LD_HU, ST_H: return 2'd1;
      LD_W, LD_WU, ST_W: return 2'd2;
      LD_D, ST_D:        return 2'd3;
      default:           return 2'd0;
    endcase
  endfunction

  function automatic logic op_is_load(op_e op);
    return op inside {LD_B, LD_BU, LD_H, LD_HU, LD_W, LD_WU, LD_D};
  endfunction

  function automatic logic op_is_store(op_e op);
    return op inside {ST_B, ST_H, ST_W, ST_D};
  endfunction

  function automatic logic op_is_signed(op_e op);
    return op inside {LD_B, LD_H, LD_W};
  endfunction

  // Undefined encodings and 64-bit-only ops on a 32-bit datapath are illegal
  function automatic logic op_legal(op_e op, int unsigned data_w);
    if (op != OP_NONE && !op_is_load(op) && !op_is_store(op)) return 1'b0;
    if (data_w == 32 && op inside {LD_WU, LD_D, ST_D}) return 1'b0;
    return 1'b1;
  endfunction

endpackage

// File: rtl/mem_access_unit_if.sv
// Data-SRAM-like bus: address phase (req/addr_ok) and data phase (data_ok).
interface mem_access_unit_if #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 32
) ();
  logic                req;
  logic                req_we;
  logic [ADDR_W-1:0]   req_addr;
  logic [DATA_W/8-1:0] req_strb;
  logic [DATA_W-1:0]   req_wdata;
  logic                addr_ok;
  logic                data_ok;
  logic [DATA_W-1:0]   rdata;

  modport master (
    output req, req_we, req_addr, req_strb, req_wdata,
    input  addr_ok, data_ok, rdata
  );

  modport slave (
    input  req, req_we, req_addr, req_strb, req_wdata,
    output addr_ok, data_ok, rdata
  );
endinterface

// File: rtl/mem_lane_fmt.sv
// Byte-lane formatting: store strobes/replicated data and load extract/extend.
module mem_lane_fmt
  import mem_pkg::*;
#(
  parameter int DATA_W = 32,
  localparam int LB = $clog2(DATA_W/8)
) (
  input  op_e                 op,
  input  logic [LB-1:0]       lane,
  input  logic [DATA_W-1:0]   sdata,
  input  logic [DATA_W-1:0]   rdata,
  output logic [DATA_W/8-1:0] strb,
  output logic [DATA_W-1:0]   wdata,
  output logic [DATA_W-1:0]   ldata
);
  logic [DATA_W/8-1:0] strb_m;
  logic [DATA_W-1:0]   sh;
  logic [DATA_W-1:0]   mask;
  logic                sgn;

  always_comb begin
    strb_m = '0;
    mask   = '0;
    sh     = rdata >> {lane, 3'b000};
    case (op_size(op))
      2'd0: begin
        strb_m[0]    = 1'b1;
        mask[7:0]    = '1;
        wdata        = {(DATA_W/8){sdata[7:0]}};
        sgn          = sh[7];
      end
      2'd1: begin
        strb_m[1:0]  = '1;
        mask[15:0]   = '1;
        wdata        = {(DATA_W/16){sdata[15:0]}};
        sgn          = sh[15];
      end
      2'd2: begin
        strb_m[3:0]  = '1;
        mask[31:0]   = '1;
        wdata        = {(DATA_W/32){sdata[31:0]}};
        sgn          = sh[31];
      end
      default: begin
        strb_m       = '1;
        mask         = '1;
        wdata        = sdata;
        sgn          = sh[DATA_W-1];
      end
    endcase
    strb  = strb_m << lane;
    ldata = (sh & mask) | ((op_is_signed(op) && sgn) ? ~mask : '0);
  end
endmodule

// File: rtl/mem_access_unit.sv
// Handshaked MEM stage: one load/store in flight on a two-phase data bus.
module mem_access_unit
  import mem_pkg::*;
#(
  parameter int DATA_W  = 32,
  parameter int ADDR_W  = 32,
  parameter int RADDR_W = 5
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               flush,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [3:0]         in_op,
  input  logic [ADDR_W-1:0]  in_addr,
  input  logic [DATA_W-1:0]  in_sdata,
  input  logic [RADDR_W-1:0] in_waddr,
  input  logic [DATA_W-1:0]  in_wdata,
  input  logic               in_we,
  mem_access_unit_if.master  bus,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [RADDR_W-1:0] out_waddr,
  output logic [DATA_W-1:0]  out_wdata,
  output logic               out_we,
  output logic               out_ale,
  output logic [ADDR_W-1:0]  out_badv
);
  localparam int LB = $clog2(DATA_W/8);

  state_e              state, state_nxt;
  op_e                 op_in, op_q;
  logic [ADDR_W-1:0]   addr_q;
  logic [DATA_W-1:0]   sdata_q, res_q;
  logic [RADDR_W-1:0]  waddr_q;
  logic                we_q, ale_q;
  logic                in_mem, in_legal, in_mis;
  logic                accept, capture;
  logic [DATA_W/8-1:0] strb;
  logic [DATA_W-1:0]   st_wdata, ld_data;

  mem_lane_fmt #(.DATA_W(DATA_W)) u_fmt (
    .op    (op_q),
    .lane  (addr_q[LB-1:0]),
    .sdata (sdata_q),
    .rdata (bus.rdata),
    .strb  (strb),
    .wdata (st_wdata),
    .ldata (ld_data)
  );

  always_comb begin
    op_in    = op_e'(in_op);
    in_mem   = op_is_load(op_in) || op_is_store(op_in);
    in_legal = op_legal(op_in, DATA_W);
    case (op_size(op_in))
      2'd0:    in_mis = 1'b0;
      2'd1:    in_mis = in_addr[0];
      2'd2:    in_mis = |in_addr[1:0];
      default: in_mis = |in_addr[2:0];
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    accept    = 1'b0;
    capture   = 1'b0;
    case (state)
      IDLE: if (in_valid && !flush) begin
        accept    = 1'b1;
        state_nxt = (in_mem && in_legal && !in_mis) ? REQ : DONE;
      end
      REQ: begin
        // addr_ok alone under flush leaves a data phase owed, so drain it
        if (flush)             state_nxt = (bus.addr_ok && !bus.data_ok) ? DRAIN : IDLE;
        else if (bus.addr_ok) begin
          if (bus.data_ok) begin
            capture   = 1'b1;
            state_nxt = DONE;
          end else begin
            state_nxt = WAIT;
          end
        end
      end
      WAIT: begin
        if (bus.data_ok) begin
          capture   = !flush;
          state_nxt = flush ? IDLE : DONE;
        end else if (flush) begin
          state_nxt = DRAIN;
        end
      end
      DONE:    if (flush || out_ready) state_nxt = IDLE;
      DRAIN:   if (bus.data_ok) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      op_q    <= OP_NONE;
      addr_q  <= '0;
      sdata_q <= '0;
      waddr_q <= '0;
      res_q   <= '0;
      we_q    <= 1'b0;
      ale_q   <= 1'b0;
    end else begin
      if (accept) begin
        op_q    <= op_in;
        addr_q  <= in_addr;
        sdata_q <= in_sdata;
        waddr_q <= in_waddr;
        res_q   <= (!in_mem && in_legal) ? in_wdata : '0;
        we_q    <= in_we && in_legal && (!in_mem || (op_is_load(op_in) && !in_mis));
        ale_q   <= in_mem && in_legal && in_mis;
      end
      if (capture) res_q <= op_is_load(op_q) ? ld_data : '0;
    end
  end

  assign in_ready      = (state == IDLE);
  assign bus.req       = (state == REQ);
  assign bus.req_we    = bus.req && op_is_store(op_q);
  assign bus.req_addr  = bus.req ? {addr_q[ADDR_W-1:LB], {LB{1'b0}}} : '0;
  assign bus.req_strb  = bus.req_we ? strb : '0;
  assign bus.req_wdata = bus.req_we ? st_wdata : '0;

  assign out_valid = (state == DONE);
  assign out_waddr = out_valid ? waddr_q : '0;
  assign out_wdata = out_valid ? res_q : '0;
  assign out_we    = out_valid && we_q;
  assign out_ale   = out_valid && ale_q;
  assign out_badv  = (out_valid && ale_q) ? addr_q : '0;
endmodule

// File: tb/tb_mem_access_unit.sv
// Bench for mem_access_unit: 32- and 64-bit instances against a lane-arithmetic model.
module tb_mem_access_unit;
  import mem_pkg::*;

  logic        clk = 1'b0;
  logic        rst, flush, in_valid, out_ready, in_we, addr_ok, data_ok, w64;
  logic [3:0]  in_op;
  logic [31:0] in_addr;
  logic [63:0] in_sdata, in_wdata, rdata;
  logic [4:0]  in_waddr;
  int          checks = 0;
  int          errors = 0;

  always #5 clk = ~clk;

  mem_access_unit_if #(.DATA_W(32), .ADDR_W(32)) b32 ();
  mem_access_unit_if #(.DATA_W(64), .ADDR_W(32)) b64 ();

  assign b32.addr_ok = addr_ok && !w64;
  assign b32.data_ok = data_ok && !w64;
  assign b32.rdata   = rdata[31:0];
  assign b64.addr_ok = addr_ok && w64;
  assign b64.data_ok = data_ok && w64;
  assign b64.rdata   = rdata;

  logic        rdy32, rdy64, ov32, ov64, we32, we64, ale32, ale64;
  logic [4:0]  wa32, wa64;
  logic [31:0] wd32, bv32, bv64;
  logic [63:0] wd64;

  mem_access_unit #(.DATA_W(32), .ADDR_W(32), .RADDR_W(5)) u32 (
    .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid && !w64), .in_ready(rdy32),
    .in_op(in_op), .in_addr(in_addr), .in_sdata(in_sdata[31:0]), .in_waddr(in_waddr),
    .in_wdata(in_wdata[31:0]), .in_we(in_we), .bus(b32), .out_valid(ov32),
    .out_ready(out_ready && !w64), .out_waddr(wa32), .out_wdata(wd32), .out_we(we32),
    .out_ale(ale32), .out_badv(bv32)
  );

  mem_access_unit #(.DATA_W(64), .ADDR_W(32), .RADDR_W(5)) u64 (
    .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid && w64), .in_ready(rdy64),
    .in_op(in_op), .in_addr(in_addr), .in_sdata(in_sdata), .in_waddr(in_waddr),
    .in_wdata(in_wdata), .in_we(in_we), .bus(b64), .out_valid(ov64),
    .out_ready(out_ready && w64), .out_waddr(wa64), .out_wdata(wd64), .out_we(we64),
    .out_ale(ale64), .out_badv(bv64)
  );

  logic        in_ready, out_valid, out_we, out_ale, req, req_we;
  logic [4:0]  out_waddr;
  logic [31:0] out_badv, req_addr;
  logic [63:0] out_wdata, req_wdata;
  logic [7:0]  req_strb;

  assign in_ready  = w64 ? rdy64 : rdy32;
  assign out_valid = w64 ? ov64 : ov32;
  assign out_we    = w64 ? we64 : we32;
  assign out_ale   = w64 ? ale64 : ale32;
  assign out_waddr = w64 ? wa64 : wa32;
  assign out_badv  = w64 ? bv64 : bv32;
  assign out_wdata = w64 ? wd64 : {32'b0, wd32};
  assign req       = w64 ? b64.req : b32.req;
  assign req_we    = w64 ? b64.req_we : b32.req_we;
  assign req_addr  = w64 ? b64.req_addr : b32.req_addr;
  assign req_strb  = w64 ? b64.req_strb : {4'b0, b32.req_strb};
  assign req_wdata = w64 ? b64.req_wdata : {32'b0, b32.req_wdata};

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %h exp %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic int unsigned size_of(logic [3:0] op);
    case (op)
      LD_H, LD_HU, ST_H: return 2;
      LD_W, LD_WU, ST_W: return 4;
      LD_D, ST_D:        return 8;
      default:           return 1;
    endcase
  endfunction

  function automatic logic [63:0] ones(int unsigned n);
    return (n >= 8) ? 64'hFFFF_FFFF_FFFF_FFFF : ((64'd1 << (8 * n)) - 64'd1);
  endfunction

  task automatic present(input logic [3:0] op, input logic [31:0] addr, input logic [63:0] sd,
                         input logic [63:0] wd, input logic [4:0] wa, input logic we);
    in_op = op; in_addr = addr; in_sdata = sd; in_wdata = wd; in_waddr = wa; in_we = we;
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
  endtask

  // One complete op: addr_ok after alat REQ cycles, data_ok dlat cycles later, WB stall rlat.
  task automatic run_op(input logic [3:0] op, input logic [31:0] addr, input logic [63:0] sd,
                        input logic [63:0] wd, input logic [63:0] rd, input logic [4:0] wa,
                        input logic we, input int unsigned alat, input int unsigned dlat,
                        input int unsigned rlat);
    int unsigned n, nb, lane, wbits;
    logic        ld, st, illegal, ale, use_bus, exp_we;
    logic [63:0] exp_strb, exp_wdata, exp_res, v, trunc;
    n     = size_of(op);
    wbits = w64 ? 64 : 32;
    nb    = wbits / 8;
    lane  = addr % nb;
    trunc = ones(nb);
    ld    = (op >= LD_B && op <= LD_D);
    st    = (op >= ST_B && op <= ST_D);
    illegal = !w64 && (op == LD_WU || op == LD_D || op == ST_D);
    ale     = (ld || st) && !illegal && (addr % n != 0);
    use_bus = (ld || st) && !illegal && !ale;
    exp_strb  = ((64'd1 << n) - 64'd1) << lane;
    exp_wdata = '0;
    for (int unsigned k = 0; k < nb / n; k++)
      exp_wdata |= (sd & ones(n)) << (k * n * 8);
    v = (rd >> (lane * 8)) & ones(n);
    if ((op == LD_B || op == LD_H || op == LD_W) && v[8*n-1]) v |= ~ones(n);
    exp_res = (op == OP_NONE) ? (wd & trunc) : (v & trunc);
    exp_we  = (op == OP_NONE || (ld && use_bus)) ? we : 1'b0;

    check("idle_ready", in_ready, 1);
    present(op, addr, sd, wd, wa, we);
    if (!use_bus) begin
      check("nobus_req", req, 0);
    end else begin
      for (int unsigned i = 0; i <= alat; i++) begin
        check("req", req, 1);
        check("req_addr", req_addr, addr - lane);
        check("req_we", req_we, st);
        if (st) begin
          check("req_strb", req_strb, exp_strb);
          check("req_wdata", req_wdata, exp_wdata & trunc);
        end
        if (i == alat) begin
          addr_ok = 1'b1;
          if (dlat == 0) begin data_ok = 1'b1; rdata = rd; end
        end
        tick();
        addr_ok = 1'b0; data_ok = 1'b0; rdata = {$urandom, $urandom};
      end
      for (int unsigned i = 1; i <= dlat; i++) begin
        check("wait_req", req, 0);
        check("wait_valid", out_valid, 0);
        if (i == dlat) begin data_ok = 1'b1; rdata = rd; end
        tick();
        data_ok = 1'b0; rdata = {$urandom, $urandom};
      end
    end
    for (int unsigned i = 0; i <= rlat; i++) begin
      check("out_valid", out_valid, 1);
      check("out_we", out_we, exp_we);
      check("out_ale", out_ale, ale);
      check("out_waddr", out_waddr, wa);
      if (ale) check("out_badv", out_badv, addr);
      if (op == OP_NONE || (ld && use_bus)) check("out_wdata", out_wdata, exp_res);
      if (i == rlat) out_ready = 1'b1;
      tick();
      out_ready = 1'b0;
    end
    check("ret_valid", out_valid, 0);
    check("ret_ready", in_ready, 1);
  endtask

  initial begin
    logic [3:0]  op;
    logic [31:0] addr;
    int unsigned off, n;
    rst = 1'b1; flush = 0; in_valid = 0; out_ready = 0; in_we = 0; addr_ok = 0; data_ok = 0;
    w64 = 0; in_op = '0; in_addr = '0; in_sdata = '0; in_wdata = '0; rdata = '0; in_waddr = '0;
    tick(); tick();
    rst = 1'b0;
    for (int s = 0; s < 2; s++) begin
      w64 = s[0];
      #1;
      check("rst_ready", in_ready, 1);
      check("rst_valid", out_valid, 0);
      check("rst_req", req, 0);
      check("rst_we", out_we, 0);
    end

    w64 = 0;
    run_op(LD_B, 32'h1003, '0, '0, 64'h80AABBCC, 5'd3, 1, 0, 1, 0);
    run_op(ST_H, 32'h2002, 64'h1234ABCD, '0, '0, 5'd4, 1, 0, 1, 0);
    run_op(LD_W, 32'h3001, '0, '0, '0, 5'd5, 1, 0, 0, 0);
    run_op(LD_D, 32'h3000, '0, '0, '0, 5'd6, 1, 0, 0, 0);
    run_op(OP_NONE, 32'h0, '0, 64'hDEADBEEF, '0, 5'd7, 1, 0, 0, 4);
    run_op(LD_HU, 32'h10, '0, '0, 64'hCAFE8001, 5'd8, 1, 0, 0, 4);
    w64 = 1;
    run_op(LD_WU, 32'h4004, '0, '0, 64'hF0000001_00000000, 5'd9, 1, 0, 1, 0);
    run_op(LD_D, 32'h4004, '0, '0, '0, 5'd10, 1, 0, 0, 0);
    run_op(ST_D, 32'h4008, 64'h0123_4567_89AB_CDEF, '0, '0, 5'd11, 0, 2, 3, 1);

    // flush in WAIT: drain the owed data phase
    w64 = 0;
    present(LD_W, 32'h5000, '0, '0, 5'd1, 1);
    check("fw_req", req, 1);
    addr_ok = 1; tick(); addr_ok = 0;
    check("fw_wait_req", req, 0);
    flush = 1; tick(); flush = 0;
    for (int i = 0; i < 5; i++) begin
      check("fw_ready", in_ready, 0);
      check("fw_valid", out_valid, 0);
      if (i == 4) data_ok = 1;
      tick();
      data_ok = 0;
    end
    check("fw_ready_after", in_ready, 1);
    check("fw_valid_after", out_valid, 0);
    run_op(LD_BU, 32'h5001, '0, '0, 64'h0000F100, 5'd2, 1, 0, 1, 0);

    // flush in REQ before addr_ok
    present(LD_H, 32'h6002, '0, '0, 5'd1, 1);
    check("fr_req", req, 1);
    flush = 1; tick(); flush = 0;
    check("fr_req_drop", req, 0);
    check("fr_ready", in_ready, 1);

    // flush with addr_ok in REQ: drain one data phase
    present(LD_W, 32'h6004, '0, '0, 5'd1, 1);
    flush = 1; addr_ok = 1; tick(); flush = 0; addr_ok = 0;
    check("fa_ready", in_ready, 0);
    data_ok = 1; tick(); data_ok = 0;
    check("fa_ready_after", in_ready, 1);
    check("fa_valid", out_valid, 0);

    // flush in DONE and flush in IDLE
    present(OP_NONE, '0, '0, 64'h55, 5'd2, 1);
    check("fd_valid", out_valid, 1);
    flush = 1; tick(); flush = 0;
    check("fd_valid_drop", out_valid, 0);
    check("fd_ready", in_ready, 1);
    flush = 1; in_valid = 1; in_op = OP_NONE; tick(); flush = 0; in_valid = 0;
    check("fi_ready", in_ready, 1);
    check("fi_valid", out_valid, 0);

    // reset mid-request
    present(LD_H, 32'h7000, '0, '0, 5'd1, 1);
    check("rr_req", req, 1);
    rst = 1; tick(); rst = 0;
    check("rr_req_drop", req, 0);
    check("rr_ready", in_ready, 1);
    check("rr_valid", out_valid, 0);

    for (int r = 0; r < 200; r++) begin
      w64  = $urandom_range(0, 1);
      op   = 4'($urandom_range(0, 11));
      addr = $urandom;
      n    = size_of(op);
      if ($urandom_range(0, 3) != 0) begin
        off  = $urandom_range(0, 7);
        addr = (addr & ~32'h7) | (off - off % n);
      end
      run_op(op, addr, {$urandom, $urandom}, {$urandom, $urandom}, {$urandom, $urandom},
             5'($urandom), 1'($urandom), $urandom_range(0, 3), $urandom_range(0, 3),
             $urandom_range(0, 2));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/mem_access_unit.md
Name: mem_access_unit

Overview:
- Parametrised, handshaked successor to the combinational MEM stage.
- Sits between the EX/MEM pipeline register and the WB stage.
- Issues one load or store at a time to a data-SRAM-like bus with an address phase and a data phase; the bus handshake is req/addr_ok/data_ok.
- Aligns and extends load data, builds store byte strobes, and detects misaligned accesses (ALE) before any bus traffic.

Parameters:
- DATA_W, 32, datapath and bus data width; legal values 32 or 64.
- ADDR_W, 32, address width.
- RADDR_W, 5, register-file write-address width.

Ports:
- clk  in  1  clock
- rst  in  1  reset
- flush  in  1  pipeline flush (exception/branch); kills the current op
- in_valid  in  1  upstream op valid
- in_ready  out  1  unit can accept an op
- in_op  in  4  memory op code (package enum)
- in_addr  in  ADDR_W  effective address
- in_sdata  in  DATA_W  store source register value
- in_waddr  in  RADDR_W  destination register
- in_wdata  in  DATA_W  ALU result for non-memory ops
- in_we  in  1  register write enable
- req  out  1  bus request
- req_we  out  1  1 = store
- req_addr  out  ADDR_W  word-aligned bus address (low lane bits zero)
- req_strb  out  DATA_W/8  byte strobes
- req_wdata  out  DATA_W  lane-replicated store data
- addr_ok  in  1  address phase accepted
- data_ok  in  1  data phase complete (loads and stores)
- rdata  in  DATA_W  load data, valid with data_ok
- out_valid  out  1  result valid to WB
- out_ready  in  1  WB accepts
- out_waddr  out  RADDR_W  destination register
- out_wdata  out  DATA_W  write-back data
- out_we  out  1  register write enable
- out_ale  out  1  address-alignment exception
- out_badv  out  ADDR_W  faulting address (valid with out_ale)

Behaviour:
- Reset: rst is synchronous, active-high.
  - FSM returns to IDLE.
  - All outputs are 0, except in_ready, which is 1.
  - req is deasserted on the cycle after rst is sampled high, even mid-transaction. Outstanding bus responses after reset are the slave's concern.
- FSM states:
  - IDLE: in_ready = 1. Accept on in_valid & in_ready; latch all inputs. Next state:
    - non-memory op (OP_NONE) -> DONE, passthrough of waddr/wdata/we.
    - illegal op for this DATA_W (LD_WU, LD_D, ST_D when DATA_W = 32) -> DONE, out_we = 0.
    - misaligned (H: addr[0] != 0; W: addr[1:0] != 0; D: addr[2:0] != 0) -> DONE, out_ale = 1, out_badv = addr, out_we = 0, no req.
    - aligned memory op -> REQ.
  - REQ: req = 1, with addr/strb/wdata held stable until addr_ok.
    - On addr_ok: go to WAIT, with req = 0 from the next cycle.
    - addr_ok and data_ok in the same cycle: go directly to DONE.
  - WAIT: on data_ok, capture and format rdata (loads) and go to DONE. data_ok never precedes addr_ok.
  - DONE: out_valid = 1, outputs stable. On out_ready go to IDLE.
  - DRAIN: entered on flush during WAIT. Wait for data_ok, discard it, then go to IDLE. out_valid stays 0.
- in_ready = (state == IDLE). One op in flight at a time.
- Minimum latency, accept to out_valid:
  - 1 cycle for non-memory, illegal and ALE ops.
  - 2 cycles for memory ops when addr_ok and data_ok arrive in the same cycle.
- Lane rules, with LB = log2(DATA_W/8) and lane = addr[LB-1:0]:
  - Load data: bytes extracted from rdata at lane*8 with size 1/2/4/8 bytes.
  - B/H/W are sign-extended; BU/HU/WU are zero-extended to DATA_W.
  - Store strobes: the size mask shifted left by lane.
  - Store data: the source slice replicated across all lanes.
- Flush:
  - In IDLE: no effect; an op presented that cycle is not accepted.
  - In REQ before addr_ok: drop req, go to IDLE.
  - In REQ in the same cycle as addr_ok: go to DRAIN, or to IDLE if data_ok is also high that cycle.
  - In WAIT: go to DRAIN.
  - In DONE: drop out_valid, go to IDLE.
- An ALE op performs no bus access and no register write.
- Stores: out_we = 0 once the access completes.

Decomposition:
- Package mem_pkg:
  - op enum OP_NONE, LD_B, LD_BU, LD_H, LD_HU, LD_W, LD_WU, LD_D, ST_B, ST_H, ST_W, ST_D.
  - FSM state enum IDLE/REQ/WAIT/DONE/DRAIN.
  - op_size() and op_is_load/store/signed helpers.
- Sub-module mem_lane_fmt (combinational): builds strb and wdata for stores; extracts and extends load data. Shared with future cache-side logic.

Test Plan:
- DATA_W=32, LD_B addr 0x1003, rdata 0x80AABBCC, addr_ok/data_ok 1 cycle later each -> out_wdata 0xFFFFFF80, req_addr 0x1000, out_valid 3 cycles after accept.
- ST_H addr 0x2002 sdata 0x1234ABCD -> req_we=1, req_strb 4'b1100, req_wdata 0xABCDABCD, out_we=0 after data_ok.
- LD_W addr 0x3001 -> no req ever; out_valid next cycle with out_ale=1, out_badv 0x3001, out_we=0.
- DATA_W=64, LD_WU addr 0x4004, rdata 0xF0000001_00000000 -> out_wdata 0x00000000_F0000001. Also: LD_D addr 0x4004 -> ALE.
- Flush in WAIT: no out_valid; in_ready stays 0 until data_ok arrives 5 cycles later, then 1. Next LD_BU completes normally with fresh data.
- rst asserted during REQ with addr_ok held low -> req=0 and in_ready=1 next cycle. Back-pressure case: out_ready low for 4 cycles holds out_valid and data stable.
